// File: rtl/restoring_divider_ctrl_pkg.sv
// rtl/restoring_divider_ctrl_pkg.sv - shared ULA types for the restoring divider
package ula_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_t;

  // Iteration counter width; it counts down from N-1.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/restoring_divider_ctrl_if.sv
// rtl/restoring_divider_ctrl_if.sv - request/result bundle between execute control and divider
interface restoring_divider_ctrl_if #(
  parameter int N = 64
);
  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/restoring_divider_ctrl_ripple_sub_adder.sv
// rtl/restoring_divider_ctrl_ripple_sub_adder.sv - ripple-carry adder/subtractor, D=1 subtracts
module rippleSubAdder #(
  parameter int N = 65
) (
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         D,
  output logic [N-1:0] S,
  output logic         Cout
);
  logic [N:0]   c;
  logic [N-1:0] bx;

  // Subtraction as A + ~B + 1; Cout=1 means no borrow.
  assign bx   = B ^ {N{D}};
  assign c[0] = D;

  for (genvar i = 0; i < N; i++) begin : g_bit
    assign S[i]   = A[i] ^ bx[i] ^ c[i];
    assign c[i+1] = (A[i] & bx[i]) | (c[i] & (A[i] ^ bx[i]));
  end

  assign Cout = c[N];
endmodule

// File: rtl/restoring_divider_ctrl.sv
// rtl/restoring_divider_ctrl.sv - multi-cycle unsigned restoring divider (DIVU/REMU)
module restoring_divider_ctrl
  import ula_pkg::*;
#(
  parameter int N = 64
) (
  input logic                     clk,
  input logic                     rst,
  restoring_divider_ctrl_if.slave div_io
);
  localparam int CNT_W = cnt_width(N);

  div_state_t       state_q, state_d;
  logic [N-1:0]     q_q, q_d;
  logic [N:0]       r_q, r_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]     div_q, div_d;
  logic [N-1:0]     quot_q, quot_d;
  logic [N-1:0]     rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic [N:0]       t;
  logic [N:0]       s;
  logic             cout;
  logic             unused_r_msb;

  // The remainder never reaches the divisor, so its top bit stays clear.
  assign unused_r_msb = r_q[N];

  rippleSubAdder #(.N(N+1)) u_sub (
    .A   (t),
    .B   ({1'b0, div_q}),
    .D   (1'b1),
    .S   (s),
    .Cout(cout)
  );

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    t       = {r_q[N-1:0], q_q[N-1]};

    case (state_q)
      CALC: begin
        r_d   = cout ? s : t;
        q_d   = {q_q[N-2:0], cout};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          quot_d  = q_d;
          rem_d   = r_d[N-1:0];
          dbz_d   = 1'b0;
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
        if (div_io.start) begin
          if (div_io.divisor != '0) begin
            q_d     = div_io.dividend;
            r_d     = '0;
            cnt_d   = CNT_W'(N-1);
            div_d   = div_io.divisor;
            state_d = CALC;
          end else begin
            quot_d  = '1;
            rem_d   = div_io.dividend;
            dbz_d   = 1'b1;
            state_d = DONE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      q_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      div_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign div_io.busy        = (state_q == CALC);
  assign div_io.done        = (state_q == DONE);
  assign div_io.quotient    = quot_q;
  assign div_io.remainder   = rem_q;
  assign div_io.div_by_zero = dbz_q;
endmodule
